// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light controller monitor: lamp vectors,
// fault codes, FSM states and the per-direction lamp sequencing rules.
package tlc_pkg;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } tlc_state_e;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_CONFLICT  = 3'd1,
        FC_INVALID   = 3'd2,
        FC_ILLEGAL   = 3'd3,
        FC_SHORT_YEL = 3'd4,
        FC_STUCK_YEL = 3'd5
    } tlc_fault_e;

    function automatic logic lamp_valid(input logic [2:0] v);
        return (v == LAMP_G) || (v == LAMP_Y) || (v == LAMP_R);
    endfunction

    // Only the forward G->Y->R->G sequence is allowed for one direction.
    function automatic logic step_legal(input logic [2:0] prev, input logic [2:0] cur);
        return ((prev == LAMP_G) && (cur == LAMP_Y)) ||
               ((prev == LAMP_Y) && (cur == LAMP_R)) ||
               ((prev == LAMP_R) && (cur == LAMP_G));
    endfunction

endpackage

// File: rtl/tlc_lamp_filter.sv
// One direction's lamp front end: two-flop synchronizer, debounce into a
// stable vector, and a saturating count of cycles the stable vector is yellow.
module tlc_lamp_filter
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_lamp,
    output logic [2:0] o_stable,
    output logic [7:0] o_yel_cnt
);

    localparam logic [7:0] DB_L = 8'(DEBOUNCE);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_cand;
    logic [2:0] r_stable;
    logic [7:0] r_cnt;
    logic [7:0] r_yel;
    logic       w_same;
    logic [7:0] w_cnt_nx;

    assign w_same = (r_sync2 == r_cand);

    // Run length of the current synchronized value, including this cycle.
    always_comb begin
        w_cnt_nx = 8'd1;
        if (w_same) begin
            w_cnt_nx = (r_cnt < DB_L) ? r_cnt + 8'd1 : r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= LAMP_OFF;
            r_sync2  <= LAMP_OFF;
            r_cand   <= LAMP_OFF;
            r_stable <= LAMP_OFF;
            r_cnt    <= 8'd0;
            r_yel    <= 8'd0;
        end else begin
            r_sync1 <= i_lamp;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_nx;
            if (w_cnt_nx >= DB_L) begin
                r_stable <= r_sync2;
            end
            if (r_stable == LAMP_Y) begin
                if (r_yel != 8'hFF) begin
                    r_yel <= r_yel + 8'd1;
                end
            end else begin
                r_yel <= 8'd0;
            end
        end
    end

    assign o_stable  = r_stable;
    assign o_yel_cnt = r_yel;

endmodule

// File: rtl/tt_um_tlc_monitor.sv
// Traffic-light controller safety monitor: watches highway/farm lamp outputs,
// latches the first (lowest-coded) fault and commands flashing red until cleared.
module tt_um_tlc_monitor
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE  = 2,
    parameter int MIN_YEL   = 3,
    parameter int MAX_YEL   = 20,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] MIN_YEL_L  = 8'(MIN_YEL);
    localparam logic [7:0] MAX_YEL_L  = 8'(MAX_YEL);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);

    logic [2:0] w_h_stable;
    logic [2:0] w_f_stable;
    logic [7:0] w_h_yel;
    logic [7:0] w_f_yel;
    logic       w_unused;

    logic [2:0] r_h_prev;
    logic [2:0] r_f_prev;
    logic       r_clr_s1;
    logic       r_clr_s2;
    logic       r_clr_d;
    tlc_state_e r_state;
    tlc_fault_e r_code;
    logic       r_flash;
    logic [7:0] r_fdiv;

    logic       w_conflict;
    logic       w_invalid;
    logic       w_illegal;
    logic       w_short;
    logic       w_stuck;
    logic       w_lamps_ok;
    logic       w_seen;
    logic       w_clr_rise;
    tlc_fault_e w_run_code;
    tlc_fault_e w_init_code;
    tlc_state_e w_nx_state;
    tlc_fault_e w_nx_code;
    logic       w_nx_flash;
    logic [7:0] w_nx_fdiv;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[7]};

    tlc_lamp_filter #(.DEBOUNCE(DEBOUNCE)) u_hwy (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_lamp    (ui_in[2:0]),
        .o_stable  (w_h_stable),
        .o_yel_cnt (w_h_yel)
    );

    tlc_lamp_filter #(.DEBOUNCE(DEBOUNCE)) u_farm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_lamp    (ui_in[5:3]),
        .o_stable  (w_f_stable),
        .o_yel_cnt (w_f_yel)
    );

    assign w_conflict = (w_h_stable != LAMP_R) && (w_f_stable != LAMP_R);
    assign w_invalid  = !lamp_valid(w_h_stable) || !lamp_valid(w_f_stable);
    assign w_illegal  = ((w_h_stable != r_h_prev) && !step_legal(r_h_prev, w_h_stable)) ||
                        ((w_f_stable != r_f_prev) && !step_legal(r_f_prev, w_f_stable));
    // The yellow count still holds the finished yellow run on the cycle red appears.
    assign w_short    = ((r_h_prev == LAMP_Y) && (w_h_stable == LAMP_R) && (w_h_yel < MIN_YEL_L)) ||
                        ((r_f_prev == LAMP_Y) && (w_f_stable == LAMP_R) && (w_f_yel < MIN_YEL_L));
    assign w_stuck    = ((w_h_stable == LAMP_Y) && (w_h_yel >= MAX_YEL_L)) ||
                        ((w_f_stable == LAMP_Y) && (w_f_yel >= MAX_YEL_L));
    assign w_lamps_ok = !w_invalid && !w_conflict;
    assign w_seen     = (w_h_stable != LAMP_OFF) && (w_f_stable != LAMP_OFF);
    assign w_clr_rise = r_clr_s2 && !r_clr_d;

    always_comb begin
        w_run_code  = FC_NONE;
        w_init_code = FC_NONE;
        if (w_conflict)     w_run_code = FC_CONFLICT;
        else if (w_invalid) w_run_code = FC_INVALID;
        else if (w_illegal) w_run_code = FC_ILLEGAL;
        else if (w_short)   w_run_code = FC_SHORT_YEL;
        else if (w_stuck)   w_run_code = FC_STUCK_YEL;
        // Before both directions have produced a debounced vector there is nothing to judge.
        if (w_seen) begin
            if (w_conflict)     w_init_code = FC_CONFLICT;
            else if (w_invalid) w_init_code = FC_INVALID;
        end
    end

    always_comb begin
        w_nx_state = r_state;
        w_nx_code  = r_code;
        w_nx_flash = r_flash;
        w_nx_fdiv  = r_fdiv;
        case (r_state)
            ST_INIT: begin
                if (w_init_code != FC_NONE) begin
                    w_nx_state = ST_FAULT;
                    w_nx_code  = w_init_code;
                    w_nx_flash = 1'b1;
                    w_nx_fdiv  = 8'd0;
                end else if (w_lamps_ok) begin
                    w_nx_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_code != FC_NONE) begin
                    w_nx_state = ST_FAULT;
                    w_nx_code  = w_run_code;
                    w_nx_flash = 1'b1;
                    w_nx_fdiv  = 8'd0;
                end
            end
            ST_FAULT: begin
                if (w_clr_rise && w_lamps_ok) begin
                    w_nx_state = ST_INIT;
                    w_nx_code  = FC_NONE;
                    w_nx_flash = 1'b0;
                    w_nx_fdiv  = 8'd0;
                end else if (r_fdiv == FLASH_LAST) begin
                    w_nx_fdiv  = 8'd0;
                    w_nx_flash = !r_flash;
                end else begin
                    w_nx_fdiv = r_fdiv + 8'd1;
                end
            end
            default: w_nx_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_prev <= LAMP_OFF;
            r_f_prev <= LAMP_OFF;
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
            r_clr_d  <= 1'b0;
            r_state  <= ST_INIT;
            r_code   <= FC_NONE;
            r_flash  <= 1'b0;
            r_fdiv   <= 8'd0;
        end else begin
            r_h_prev <= w_h_stable;
            r_f_prev <= w_f_stable;
            r_clr_s1 <= ui_in[6];
            r_clr_s2 <= r_clr_s1;
            r_clr_d  <= r_clr_s2;
            r_state  <= w_nx_state;
            r_code   <= w_nx_code;
            r_flash  <= w_nx_flash;
            r_fdiv   <= w_nx_fdiv;
        end
    end

    assign uo_out  = {1'b0, r_state, r_code, r_flash, (r_state == ST_FAULT)};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_tlc_monitor.sv
// Directed scenarios plus a randomized lamp walk, all checked against a
// history-window reference model of the monitor.
module tb_tt_um_tlc_monitor;

    localparam int DB   = 2;
    localparam int MINY = 3;
    localparam int MAXY = 20;
    localparam int FD   = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] hist[$];
    logic [2:0] m_hs, m_fs, m_hp, m_fp;
    int         m_hy, m_fy, m_state, m_code, m_age;

    always #5 clk = ~clk;

    tt_um_tlc_monitor #(
        .DEBOUNCE (DB),
        .MIN_YEL  (MINY),
        .MAX_YEL  (MAXY),
        .FLASH_DIV(FD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Input history value (shifted) at a given edge index; before reset release it reads as zero.
    function automatic logic [2:0] lamp_at(input int idx, input int sh);
        logic [7:0] v;
        v = (idx < 0) ? 8'h00 : hist[idx];
        v = v >> sh;
        return v[2:0];
    endfunction

    function automatic bit valid3(input logic [2:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic bit legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == 3'b001 && c == 3'b010) || (p == 3'b010 && c == 3'b100) ||
               (p == 3'b100 && c == 3'b001);
    endfunction

    function automatic logic [7:0] m_expect();
        logic [1:0] st;
        logic [2:0] cd;
        logic       fl;
        st = 2'(m_state);
        cd = 3'(m_code);
        fl = (m_state == 2) && (((m_age / FD) % 2) == 0);
        return {1'b0, st, cd, fl, (m_state == 2)};
    endfunction

    task automatic model_reset();
        hist.delete();
        m_hs = 3'b000; m_fs = 3'b000; m_hp = 3'b000; m_fp = 3'b000;
        m_hy = 0; m_fy = 0; m_state = 0; m_code = 0; m_age = 0;
    endtask

    // Advance the model by one clock edge at which ui_in == u.
    task automatic model_edge(input logic [7:0] u);
        int n, code;
        logic [2:0] h2, f2, nh, nf, c2, c3;
        bit hsteady, fsteady, rise, conflict, inv, ill, shorty, stuck, ok;
        hist.push_back(u);
        n = hist.size() - 1;
        h2 = lamp_at(n - 2, 0);
        f2 = lamp_at(n - 2, 3);
        hsteady = 1'b1;
        fsteady = 1'b1;
        for (int k = 3; k <= DB + 1; k++) begin
            if (lamp_at(n - k, 0) != h2) hsteady = 1'b0;
            if (lamp_at(n - k, 3) != f2) fsteady = 1'b0;
        end
        nh = hsteady ? h2 : m_hs;
        nf = fsteady ? f2 : m_fs;
        c2 = lamp_at(n - 2, 6);
        c3 = lamp_at(n - 3, 6);
        rise = c2[0] && !c3[0];

        conflict = (m_hs != 3'b100) && (m_fs != 3'b100);
        inv      = !valid3(m_hs) || !valid3(m_fs);
        ill      = (m_hs != m_hp && !legal_step(m_hp, m_hs)) ||
                   (m_fs != m_fp && !legal_step(m_fp, m_fs));
        shorty   = (m_hp == 3'b010 && m_hs == 3'b100 && m_hy < MINY) ||
                   (m_fp == 3'b010 && m_fs == 3'b100 && m_fy < MINY);
        stuck    = (m_hs == 3'b010 && m_hy >= MAXY) || (m_fs == 3'b010 && m_fy >= MAXY);
        code     = conflict ? 1 : inv ? 2 : ill ? 3 : shorty ? 4 : stuck ? 5 : 0;
        ok       = !conflict && !inv;

        case (m_state)
            0: begin
                if (m_hs != 3'b000 && m_fs != 3'b000 && (conflict || inv)) begin
                    m_state = 2; m_code = conflict ? 1 : 2; m_age = 0;
                end else if (ok) begin
                    m_state = 1;
                end
            end
            1: begin
                if (code != 0) begin
                    m_state = 2; m_code = code; m_age = 0;
                end
            end
            default: begin
                if (rise && ok) begin
                    m_state = 0; m_code = 0; m_age = 0;
                end else begin
                    m_age++;
                end
            end
        endcase

        m_hy = (m_hs == 3'b010) ? ((m_hy < 255) ? m_hy + 1 : 255) : 0;
        m_fy = (m_fs == 3'b010) ? ((m_fy < 255) ? m_fy + 1 : 255) : 0;
        m_hp = m_hs;
        m_fp = m_fs;
        m_hs = nh;
        m_fs = nf;
    endtask

    task automatic step(input logic [7:0] u, input string tag);
        ui_in = u;
        @(posedge clk);
        model_edge(u);
        #1;
        chk(tag, uo_out, m_expect());
    endtask

    task automatic hold(input logic [7:0] u, input int n, input string tag);
        for (int i = 0; i < n; i++) step(u, tag);
    endtask

    function automatic logic [7:0] phase_lamps(input int p);
        case (p)
            0:       return 8'h21;
            1:       return 8'h22;
            2:       return 8'h0C;
            default: return 8'h14;
        endcase
    endfunction

    initial begin
        logic [7:0] v;
        int phase, dur;
        model_reset();

        #12;
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        #10;
        rst_n = 1'b1;

        // Legal full cycle
        hold(8'h21, 8, "legal_hg_fr");
        chk("legal_run_hg", uo_out, 8'h20);
        hold(8'h22, 5, "legal_hy");
        chk("legal_run_hy", uo_out, 8'h20);
        hold(8'h0C, 8, "legal_hr_fg");
        chk("legal_run_fg", uo_out, 8'h20);
        hold(8'h14, 5, "legal_fy");
        chk("legal_run_fy", uo_out, 8'h20);
        hold(8'h21, 8, "legal_back");
        chk("legal_run_back", uo_out, 8'h20);

        // Conflict: fault exactly on the 5th edge, flash 1 for four cycles then 0
        for (int i = 0; i < 4; i++) begin
            step(8'h09, "conflict_pre");
            chk("conflict_no_fault_yet", uo_out, 8'h20);
        end
        step(8'h09, "conflict_e5");
        chk("conflict_edge5", uo_out, 8'h47);
        hold(8'h09, 3, "conflict_hold");
        chk("flash_high", uo_out, 8'h47);
        step(8'h09, "conflict_toggle");
        chk("flash_low", uo_out, 8'h45);
        step(8'h09, "conflict_last");

        // Clear while still conflicting is discarded
        hold(8'h49, 4, "clr_discard");
        chk("clr_discard_state", {6'd0, uo_out[6:5]}, 8'h02);
        chk("clr_discard_code", {5'd0, uo_out[4:2]}, 8'h01);
        hold(8'h09, 2, "clr_low");
        hold(8'h0C, 6, "restore_hr_fg");
        hold(8'h4C, 2, "clr_edge");
        step(8'h4C, "clr_init");
        chk("clr_to_init", uo_out, 8'h00);
        step(8'h4C, "clr_run");
        chk("clr_to_run", uo_out, 8'h20);

        // Clear held high must not clear a new fault
        hold(8'h49, 10, "held_clr_fault");
        chk("held_clr_faulted", {6'd0, uo_out[6:5]}, 8'h02);
        hold(8'h0C, 6, "held_clr_release");
        chk("held_clr_no_reclear", {6'd0, uo_out[6:5]}, 8'h02);
        hold(8'h4C, 3, "reclear");
        chk("reclear_init", uo_out, 8'h00);
        step(8'h4C, "reclear_run");
        chk("reclear_run", uo_out, 8'h20);
        hold(8'h0C, 2, "idle");

        // Short yellow
        hold(8'h14, 5, "sy_fy");
        hold(8'h21, 6, "sy_hg");
        hold(8'h22, 2, "sy_hy2");
        hold(8'h24, 4, "sy_hr");
        chk("short_yel_pre", uo_out, 8'h20);
        step(8'h24, "sy_e5");
        chk("short_yel_code4", uo_out, 8'h53);
        hold(8'h64, 3, "sy_clear");
        chk("sy_clear_init", uo_out, 8'h00);
        step(8'h64, "sy_clear_run");
        chk("sy_clear_run", uo_out, 8'h20);
        hold(8'h24, 3, "sy_idle");

        // One-cycle glitch to an invalid vector is filtered
        step(8'h23, "glitch");
        hold(8'h24, 6, "glitch_after");
        chk("glitch_no_fault", uo_out, 8'h20);

        // Invalid highway with farm green: conflict code wins
        hold(8'h0E, 4, "simul_pre");
        chk("simul_pre_run", uo_out, 8'h20);
        step(8'h0E, "simul_e5");
        chk("simul_code1", uo_out, 8'h47);
        hold(8'h0E, 2, "simul_hold");

        // Asynchronous reset mid-fault
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_uo_out", uo_out, 8'h00);
        chk("arst_uio_oe", uio_oe, 8'h00);
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        chk("arst_held", uo_out, 8'h00);
        rst_n = 1'b1;
        model_reset();

        // Randomized lamp walk with occasional garbage and clear pulses
        phase = 3;
        for (int seg = 0; seg < 90; seg++) begin
            if ($urandom_range(0, 9) == 0) begin
                v   = 8'($urandom_range(0, 63));
                dur = $urandom_range(1, 4);
            end else begin
                phase = (phase + 1) % 4;
                v     = phase_lamps(phase);
                dur   = (phase == 1 || phase == 3) ? $urandom_range(1, 24) : $urandom_range(2, 10);
            end
            if ($urandom_range(0, 3) == 0) v = v | 8'h40;
            hold(v, dur, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_tlc_monitor.md
TT_UM_TLC_MONITOR -- requirements
Module: tt_um_tlc_monitor

Interface
REQ-001 SHALL provide parameter DEBOUNCE, default 2: consecutive unchanged synchronized cycles before a lamp vector is stable.
REQ-002 SHALL provide parameter MIN_YEL, default 3: minimum stable-yellow cycles before red is legal.
REQ-003 SHALL provide parameter MAX_YEL, default 20: stable-yellow cycle count at which yellow is stuck.
REQ-004 SHALL provide parameter FLASH_DIV, default 4: cycles per toggle of the flash output while faulted.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ena, input, 1: ignored.
REQ-008 SHALL have port ui_in, input, 8: [2:0] highway lamps {R,Y,G}; [5:3] farm lamps {R,Y,G}; [6] fault clear; [7] unused.
REQ-009 SHALL have port uo_out, output, 8: [0] fault; [1] flash-red command; [4:2] fault code; [6:5] FSM state; [7] 0.
REQ-010 SHALL have port uio_in, input, 8: ignored.
REQ-011 SHALL have ports uio_out and uio_oe, output, 8: both constant 0.

Function
REQ-012 SHALL pass ui_in[6:0] through a two-flop synchronizer before any use.
REQ-013 SHALL treat a 3-bit lamp vector as valid only when exactly one bit is set (G=001, Y=010, R=100).
REQ-014 SHALL update the stable vector per direction when the synchronized vector has been unchanged for DEBOUNCE cycles; glitches shorter than that SHALL be ignored.
REQ-015 SHALL count stable-yellow cycles per direction in an 8-bit saturating counter, cleared whenever the stable vector leaves yellow.
REQ-016 SHALL implement FSM states INIT=00, RUN=01, FAULT=10.
REQ-017 INIT SHALL move to RUN when both stable vectors are valid and at least one is red; only codes 1 and 2 are checked in INIT.
REQ-018 RUN SHALL check all fault codes: 1 conflict (neither direction red); 2 invalid vector; 3 illegal transition (only G->Y, Y->R, R->G permitted per direction); 4 Y->R with yellow count < MIN_YEL; 5 yellow count reaching MAX_YEL.
REQ-019 On simultaneous faults the lowest code SHALL be latched.
REQ-020 Fault detection SHALL register on the clock edge after the stable-vector update, giving 3+DEBOUNCE edges from the ui_in change to fault=1.
REQ-021 FAULT SHALL hold fault=1 and the latched code, ignoring further faults.
REQ-022 In FAULT, uo_out[1] SHALL toggle every FLASH_DIV cycles, starting at 1 on entry; it SHALL be 0 outside FAULT.
REQ-023 FAULT SHALL exit to INIT only on a synchronized rising edge of clear while the current stable vectors are valid with at least one red; otherwise the clear edge is discarded.
REQ-024 Clear held high SHALL NOT re-clear; a new rising edge SHALL be required.
REQ-025 On the FAULT->INIT transition, fault, code and flash SHALL return to 0.

Reset
REQ-026 rst_n low SHALL asynchronously force state INIT, fault 0, code 000, flash 0, counters 0, synchronizers 0, and stable vectors 000.
REQ-027 Reset asserted mid-FAULT SHALL discard the latched fault; no state is retained.

Structure
REQ-028 Lamp encodings, fault codes 0-5 and FSM state encodings SHALL live in shared package tlc_pkg, reused by tt_um_tlc.
REQ-029 Per-direction synchronization, debounce and yellow counting SHALL be sub-module tlc_lamp_filter, instantiated twice.

Verification
REQ-030 Legal cycle: HG/FR, then HY for 5 cycles, then HR/FG, FY for 5 cycles, then FR/HG -> fault stays 0 and state stays 01 throughout.
REQ-031 Conflict: highway=001 and farm=001 for 10 cycles -> fault=1 and code=001 exactly 5 edges after the input change; flash toggles every 4 cycles.
REQ-032 Short yellow: highway Y for 2 stable cycles, then R -> code=100; a 1-cycle glitch to 011 -> no fault.
REQ-033 Simultaneous faults: highway=110 (invalid) with farm=001 -> code=001, because the lower code wins.
REQ-034 Clear: clear edge while inputs still conflict -> remains FAULT; inputs restored to HR/FG, then a new edge -> state 00, then 01, with all outputs 0.
REQ-035 Reset: rst_n pulsed low in FAULT -> uo_out=0 immediately (asynchronous), uio_oe=0.
